ama_riscv_mem_arbiter: RTL and testbench

//  Shares one unified memory port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).

---
 rtl/ama_riscv_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ama_riscv_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the load/store stage.
// One transaction in flight at a time: arbitrate in IDLE, hold the request in ISSUE, route the response in WAIT.
module ama_riscv_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction fetch port
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rdata,
    // load/store port
    input  logic                  d_req,
    input  logic [DATA_W/8-1:0]   d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rsp_valid,
    output logic [DATA_W-1:0]     d_rdata,
    // memory port
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [DATA_W/8-1:0]   m_we,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_rsp_valid,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic              owner_if_q, owner_if_d;
    logic              drop_q,     drop_d;
    logic [SW-1:0]     streak_q,   streak_d;
    logic [BE_W-1:0]   we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;

    logic in_idle;
    logic starved;
    logic if_elig;
    logic pick_d;
    logic pick_if;
    logic gnt_d_c;
    logic gnt_if_c;
    logic rsp_done;
    logic drop_now;

    assign in_idle  = (state_q == ST_IDLE);
    assign starved  = (streak_q == SW'(STARVE_MAX));
    // A flush cancels the fetch stream, so IF may not be granted in that cycle.
    assign if_elig  = if_req && !if_flush;
    assign pick_d   = d_req && !(if_elig && starved);
    assign pick_if  = if_elig && !pick_d;

    // Outputs are gated by rst_n so nothing pulses while reset is held.
    assign gnt_d_c  = rst_n && in_idle && pick_d;
    assign gnt_if_c = rst_n && in_idle && pick_if;
    assign rsp_done = rst_n && (state_q == ST_WAIT) && m_rsp_valid;
    // A flush arriving with the response itself still discards it.
    assign drop_now = drop_q || if_flush;

    assign if_gnt       = gnt_if_c;
    assign d_gnt        = gnt_d_c;
    assign if_rsp_valid = rsp_done && owner_if_q && !drop_now;
    assign d_rsp_valid  = rsp_done && !owner_if_q;
    assign if_rdata     = m_rdata;
    assign d_rdata      = m_rdata;

    assign m_req_valid  = rst_n && (state_q == ST_ISSUE);
    assign m_we         = we_q;
    assign m_addr       = addr_q;
    assign m_wdata      = wdata_q;

    always_comb begin
        state_d    = state_q;
        owner_if_d = owner_if_q;
        drop_d     = drop_q;
        streak_d   = streak_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (gnt_if_c) begin
                    state_d    = ST_ISSUE;
                    owner_if_d = 1'b1;
                    addr_d     = if_addr;
                    we_d       = '0;
                    wdata_d    = '0;
                    streak_d   = '0;
                end else if (gnt_d_c) begin
                    state_d    = ST_ISSUE;
                    owner_if_d = 1'b0;
                    addr_d     = d_addr;
                    we_d       = d_we;
                    wdata_d    = d_wdata;
                    // Count data wins only while fetch is actually waiting.
                    if (!if_req)
                        streak_d = '0;
                    else if (!starved)
                        streak_d = streak_q + SW'(1);
                end
            end
            ST_ISSUE: begin
                if (owner_if_q && if_flush)
                    drop_d = 1'b1;
                if (m_req_ready)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (owner_if_q && if_flush)
                    drop_d = 1'b1;
                if (m_rsp_valid) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_if_q <= 1'b0;
            drop_q     <= 1'b0;
            streak_q   <= '0;
            we_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_if_q <= owner_if_d;
            drop_q     <= drop_d;
            streak_q   <= streak_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Directed scenarios plus a randomized run checked by a scoreboard against a behavioural arbiter/memory model.
module tb_ama_riscv_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, d_req, m_req_ready, m_rsp_valid;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_we;
    logic        if_gnt, if_rsp_valid, d_gnt, d_rsp_valid, m_req_valid;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_we;

    always #5 clk = ~clk;

    ama_riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: event seen, none expected", nm);
    endtask

    // ---------------- reference memory (one copy for expectations, one acting as the memory) ----
    logic [31:0] ref_mem [int];
    logic [31:0] mem_m   [int];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rd(input bit sel, input logic [31:0] a);
        int k = int'(a >> 2);
        if (sel) return ref_mem.exists(k) ? ref_mem[k] : dflt(a);
        return mem_m.exists(k) ? mem_m[k] : dflt(a);
    endfunction

    task automatic wr(input bit sel, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        int k;
        w = rd(sel, a);
        k = int'(a >> 2);
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        if (sel) ref_mem[k] = w;
        else     mem_m[k] = w;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { bit own_if; bit drop; bit load; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; } mreq_t;

    exp_t  exp_q[$];
    mreq_t req_q[$];

    bit          mon_en = 1'b0;
    int          streak = 0;
    int          acc_cnt = 0;
    bit          prev_gnt = 1'b0, prev_stall = 1'b0;
    bit          if_gnt_seen, d_gnt_seen, acc_seen;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_we;

    task automatic monitor_cycle();
        bit    idle, done;
        int    g, eg;
        exp_t  e;
        mreq_t r;
        idle = (exp_q.size() == 0);
        done = 1'b0;
        if (prev_gnt)   chk("req_after_gnt", m_req_valid, 1'b1);
        if (prev_stall) chk("req_held", m_req_valid, 1'b1);
        prev_gnt   = if_gnt || d_gnt;
        prev_stall = m_req_valid && !m_req_ready;
        // response routing
        if (acc_cnt > 0 && m_rsp_valid) begin
            e = exp_q.pop_front();
            acc_cnt = 0;
            done = 1'b1;
            if (if_flush && e.own_if) e.drop = 1'b1;
            chk("if_rsp_valid", if_rsp_valid, e.own_if && !e.drop);
            chk("d_rsp_valid", d_rsp_valid, !e.own_if);
            if (e.own_if && !e.drop) chk("if_rdata", if_rdata, e.data);
            if (!e.own_if && e.load) chk("d_rdata", d_rdata, e.data);
        end else if (if_rsp_valid || d_rsp_valid) begin
            fail("rsp_spurious");
        end
        if (!done && if_flush && exp_q.size() > 0 && exp_q[0].own_if) begin
            e = exp_q.pop_front();
            e.drop = 1'b1;
            exp_q.push_front(e);
        end
        // memory request contents at acceptance
        if (m_req_valid && m_req_ready) begin
            if (req_q.size() == 0) fail("m_req_unexpected");
            else begin
                r = req_q.pop_front();
                chk("m_addr", m_addr, r.addr);
                chk("m_we", m_we, r.we);
                chk("m_wdata", m_wdata, r.wdata);
                acc_cnt = 1;
            end
        end
        // arbitration: data first unless fetch has lost SMAX times in a row
        g  = int'({d_gnt, if_gnt});
        eg = 0;
        if (idle) begin
            if (d_req && !(if_req && !if_flush && streak == SMAX)) eg = 2;
            else if (if_req && !if_flush)                           eg = 1;
        end
        chk("grant", g, eg);
        if (g == 2) begin
            streak  = if_req ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
            e.own_if = 1'b0;
            e.drop   = 1'b0;
            e.load   = (d_we == 4'h0);
            e.data   = rd(1'b1, d_addr);
            if (d_we != 4'h0) wr(1'b1, d_addr, d_we, d_wdata);
            exp_q.push_back(e);
            r.addr = d_addr; r.we = d_we; r.wdata = d_wdata;
            req_q.push_back(r);
        end else if (g == 1) begin
            streak   = 0;
            e.own_if = 1'b1;
            e.drop   = 1'b0;
            e.load   = 1'b1;
            e.data   = rd(1'b1, if_addr);
            exp_q.push_back(e);
            r.addr = if_addr; r.we = 4'h0; r.wdata = 32'h0;
            req_q.push_back(r);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if_gnt_seen = if_gnt;
        d_gnt_seen  = d_gnt;
        acc_seen    = m_req_valid && m_req_ready;
        acc_addr    = m_addr;
        acc_we      = m_we;
        acc_wdata   = m_wdata;
        if (mon_en) monitor_cycle();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(); @(posedge clk); #1; endtask
    task automatic smp();  @(negedge clk);     endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        if_req = 0; if_flush = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_req_ready = 0; m_rsp_valid = 0; m_rdata = 0;
        tick();
        rst_n = 1'b1;
    endtask

    int glog[64];
    int rlog[64];

    // Simple memory answering one cycle after acceptance; requesters drop after grant unless kept.
    task automatic dir_run(input int n, input bit keep_if, input bit keep_d);
        int cnt = -1;
        for (int c = 0; c < n; c++) begin
            smp();
            glog[c] = int'({d_gnt, if_gnt});
            rlog[c] = int'({d_rsp_valid, if_rsp_valid});
            if (m_req_valid && m_req_ready) cnt = 0;
            tick();
            if (glog[c] == 1 && !keep_if) if_req = 1'b0;
            if (glog[c] == 2 && !keep_d)  d_req = 1'b0;
            m_rsp_valid = (cnt == 0);
            m_rdata = 32'hC0DE_0000 + 32'(c);
            if (cnt >= 0) cnt--;
        end
    endtask

    int          mcnt = -1;
    logic [31:0] mdata;

    task automatic rand_cycle(input bit allow_new);
        tick();
        if (if_gnt_seen) if_req = 1'b0;
        if (d_gnt_seen)  d_req = 1'b0;
        if (allow_new) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 31)) << 2;
            end
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req   = 1'b1;
                d_addr  = 32'($urandom_range(0, 31)) << 2;
                d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                d_wdata = $urandom;
            end
        end else begin
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        if_flush    = ($urandom_range(0, 11) == 0);
        m_req_ready = ($urandom_range(0, 3) != 0);
        if (acc_seen) begin
            mcnt = $urandom_range(0, 2);
            if (acc_we != 4'h0) begin
                wr(1'b0, acc_addr, acc_we, acc_wdata);
                mdata = $urandom;
            end else begin
                mdata = rd(1'b0, acc_addr);
            end
        end
        m_rsp_valid = 1'b0;
        m_rdata     = $urandom;
        if (mcnt == 0) begin
            m_rsp_valid = 1'b1;
            m_rdata     = mdata;
        end else if (mcnt < 0 && $urandom_range(0, 7) == 0) begin
            m_rsp_valid = 1'b1;
        end
        if (mcnt >= 0) mcnt--;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [9:0]  seq;
        rst_n = 1'b0;
        if_req = 0; if_flush = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_req_ready = 0; m_rsp_valid = 0; m_rdata = 0;

        // reset state
        do_reset();
        smp();
        chk("rst_state", {m_req_valid, if_gnt, d_gnt, if_rsp_valid, d_rsp_valid, m_we, m_addr, m_wdata}, '0);

        // fetch with two-cycle memory latency
        tick(); if_req = 1; if_addr = 32'h100; m_req_ready = 1;
        smp();  chk("t1_gnt", {if_gnt, d_gnt, m_req_valid}, 3'b100);
        tick(); if_req = 0;
        smp();  chk("t1_issue", {m_req_valid, if_gnt, m_addr}, {2'b10, 32'h100});
        tick();
        smp();  chk("t1_wait", {m_req_valid, if_rsp_valid}, 2'b00);
        tick(); m_rsp_valid = 1; m_rdata = 32'hDEAD_BEEF;
        smp();  chk("t1_rsp", {if_rsp_valid, d_rsp_valid, if_rdata}, {2'b10, 32'hDEAD_BEEF});
        tick(); m_rsp_valid = 0;

        // data wins a simultaneous request; fetch follows in the next IDLE cycle
        do_reset();
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h2000; m_req_ready = 1;
        dir_run(7, 1'b0, 1'b0);
        chk("t2_first_gnt", glog[0], 2);
        chk("t2_d_rsp", rlog[2], 2);
        chk("t2_if_gnt", glog[3], 1);
        chk("t2_if_rsp", rlog[5], 1);

        // starvation guarantee
        do_reset();
        if_req = 1; if_addr = 32'h84; d_req = 1; d_we = 0; d_addr = 32'h2004; m_req_ready = 1;
        dir_run(30, 1'b1, 1'b1);
        n = 0; seq = '0;
        for (int c = 0; c < 30; c++)
            if (glog[c] != 0) begin
                n++;
                seq = {seq[8:0], glog[c] == 1};
            end
        chk("t3_count", n, 10);
        chk("t3_order", seq, 10'b0000100001);
        if_req = 0; d_req = 0;

        // flush: blocks grant in IDLE, discards an in-flight fetch response
        do_reset();
        if_req = 1; if_addr = 32'h200; if_flush = 1; m_req_ready = 1;
        smp();  chk("t4_flush_idle", if_gnt, 1'b0);
        tick(); if_flush = 0;
        smp();  chk("t4_gnt", if_gnt, 1'b1);
        tick(); if_req = 0;
        smp();
        tick(); if_flush = 1;
        smp();
        tick(); if_flush = 0; m_rsp_valid = 1; m_rdata = 32'h1234_5678;
        smp();  chk("t4_dropped", {if_rsp_valid, d_rsp_valid}, 2'b00);
        tick(); m_rsp_valid = 0; if_req = 1; if_addr = 32'h300;
        smp();  chk("t4_gnt2", if_gnt, 1'b1);
        tick(); if_req = 0;
        smp();
        tick(); m_rsp_valid = 1; m_rdata = 32'hCAFE_F00D;
        smp();  chk("t4_rsp2", {if_rsp_valid, if_rdata}, {1'b1, 32'hCAFE_F00D});
        tick(); m_rsp_valid = 0;

        // store under backpressure
        do_reset();
        d_req = 1; d_we = 4'b0011; d_addr = 32'h40; d_wdata = 32'hA5A5; m_req_ready = 0;
        smp();  chk("t5_gnt", d_gnt, 1'b1);
        tick(); d_req = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("t5_hold", {m_req_valid, m_we, m_addr, m_wdata}, {1'b1, 4'h3, 32'h40, 32'hA5A5});
            tick();
        end
        m_req_ready = 1;
        smp();  chk("t5_accept", m_req_valid, 1'b1);
        tick(); m_req_ready = 0;
        smp();  chk("t5_wait", {m_req_valid, d_rsp_valid}, 2'b00);
        tick(); m_rsp_valid = 1;
        smp();  chk("t5_ack", {d_rsp_valid, if_rsp_valid}, 2'b10);
        tick(); m_rsp_valid = 0;

        // reset while waiting for a response
        do_reset();
        if_req = 1; if_addr = 32'h500; m_req_ready = 1;
        smp();  chk("t6_gnt", if_gnt, 1'b1);
        tick(); if_req = 0;
        smp();
        tick(); rst_n = 0; m_rsp_valid = 1; m_rdata = 32'hBAD0_BAD0;
        smp();  chk("t6_rsp_in_rst", {if_rsp_valid, d_rsp_valid}, 2'b00);
        tick(); rst_n = 1;
        smp();  chk("t6_after_rst", {m_req_valid, if_gnt, d_gnt, if_rsp_valid, d_rsp_valid, m_we, m_addr, m_wdata}, '0);
        tick(); m_rsp_valid = 0; if_req = 1; if_addr = 32'h600;
        smp();  chk("t6_gnt2", if_gnt, 1'b1);
        tick(); if_req = 0;
        smp();  chk("t6_issue2", {m_req_valid, m_addr}, {1'b1, 32'h600});
        tick(); m_rsp_valid = 1; m_rdata = 32'h600D;
        smp();  chk("t6_rsp2", {if_rsp_valid, if_rdata}, {1'b1, 32'h600D});
        tick(); m_rsp_valid = 0;

        // randomized traffic against the scoreboard
        do_reset();
        streak = 0; acc_cnt = 0; prev_gnt = 0; prev_stall = 0; mcnt = -1;
        exp_q.delete(); req_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
        for (int i = 0; i < 40; i++)   rand_cycle(1'b0);
        smp();
        chk("drain_rsp", exp_q.size(), 0);
        chk("drain_req", req_q.size(), 0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
